// File: rtl/bram_arb_pkg.sv
// Shared constants for the two-port BRAM arbiter: FSM encodings, owner ids and default widths.
package bram_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned RD_LAT_DEF = 1;

  // Wait counter must hold the largest legal read latency (4).
  localparam int unsigned CNT_W = 3;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_VID = 1'b1;

endpackage

// File: rtl/bram_arb_rr2.sv
// Combinational two-way round-robin picker: on a tie the port that did not win last time wins.
module bram_arb_rr2
  import bram_arb_pkg::*;
(
  input  logic req_cpu,
  input  logic req_vid,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant_owner
);

  always_comb begin
    grant_valid = req_cpu | req_vid;
    if (req_cpu && req_vid) begin
      grant_owner = ~last_owner;
    end else if (req_vid) begin
      grant_owner = OWN_VID;
    end else begin
      grant_owner = OWN_CPU;
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port BRAM between the CPU and video requesters; accesses are serialised
// through IDLE -> ISSUE (-> WAIT for reads) and read data returns with a one-cycle valid pulse.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              vid_req,
  input  logic              vid_we,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic [DATA_W-1:0] vid_wdata,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0]       state_q, state_d;
  logic             last_owner_q;
  logic             owner_q;
  logic             we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             grant_valid;
  logic             grant_owner;
  logic             grant;
  logic             ret;

  bram_arb_rr2 u_rr2 (
    .req_cpu    (cpu_req),
    .req_vid    (vid_req),
    .last_owner (last_owner_q),
    .grant_valid(grant_valid),
    .grant_owner(grant_owner)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant   = 1'b0;
    ret     = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          grant   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          cnt_d   = CNT_W'(RD_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Count of 1 marks the cycle in which mem_rdata carries the issued read.
        if (cnt_q == CNT_W'(1)) begin
          ret     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_owner_q <= OWN_VID;
      owner_q      <= OWN_CPU;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      cpu_rdata    <= '0;
      vid_rdata    <= '0;
      cpu_rvalid   <= 1'b0;
      vid_rvalid   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cpu_rvalid <= ret && (owner_q == OWN_CPU);
      vid_rvalid <= ret && (owner_q == OWN_VID);
      if (grant) begin
        owner_q      <= grant_owner;
        last_owner_q <= grant_owner;
        if (grant_owner == OWN_VID) begin
          we_q    <= vid_we;
          addr_q  <= vid_addr;
          wdata_q <= vid_wdata;
        end else begin
          we_q    <= cpu_we;
          addr_q  <= cpu_addr;
          wdata_q <= cpu_wdata;
        end
      end
      if (ret && (owner_q == OWN_CPU)) cpu_rdata <= mem_rdata;
      if (ret && (owner_q == OWN_VID)) vid_rdata <= mem_rdata;
    end
  end

  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_ack   = mem_en & (owner_q == OWN_CPU);
  assign vid_ack   = mem_en & (owner_q == OWN_VID);

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter: directed accesses push expected acks/read returns,
// a negedge monitor pops and compares; a second RD_LAT=3 instance covers reset during a read.
module tb_bram_port_arbiter;
  import bram_arb_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0;
  logic        vid_req = 1'b0, vid_we = 1'b0;
  logic [15:0] vid_addr = '0, vid_wdata = '0;
  logic        cpu_ack, cpu_rvalid, vid_ack, vid_rvalid, mem_en, mem_we;
  logic [15:0] cpu_rdata, vid_rdata, mem_addr, mem_wdata, mem_rdata;

  bram_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .vid_req(vid_req), .vid_we(vid_we), .vid_addr(vid_addr), .vid_wdata(vid_wdata),
    .vid_ack(vid_ack), .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Second instance with a 3-cycle read latency, memory data tied to a constant.
  logic        r3_reset = 1'b1;
  logic        r3_cpu_req = 1'b0, r3_cpu_we = 1'b0;
  logic [15:0] r3_cpu_addr = '0, r3_cpu_wdata = '0;
  logic        r3_vid_req = 1'b0, r3_vid_we = 1'b0;
  logic [15:0] r3_vid_addr = '0, r3_vid_wdata = '0;
  logic        r3_cpu_ack, r3_cpu_rvalid, r3_vid_ack, r3_vid_rvalid, r3_mem_en, r3_mem_we;
  logic [15:0] r3_cpu_rdata, r3_vid_rdata, r3_mem_addr, r3_mem_wdata;
  logic [15:0] r3_mem_rdata = 16'h5A5A;

  bram_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(3)) u_dut3 (
    .clk(clk), .reset(r3_reset),
    .cpu_req(r3_cpu_req), .cpu_we(r3_cpu_we), .cpu_addr(r3_cpu_addr),
    .cpu_wdata(r3_cpu_wdata), .cpu_ack(r3_cpu_ack), .cpu_rdata(r3_cpu_rdata),
    .cpu_rvalid(r3_cpu_rvalid),
    .vid_req(r3_vid_req), .vid_we(r3_vid_we), .vid_addr(r3_vid_addr),
    .vid_wdata(r3_vid_wdata), .vid_ack(r3_vid_ack), .vid_rdata(r3_vid_rdata),
    .vid_rvalid(r3_vid_rvalid),
    .mem_en(r3_mem_en), .mem_we(r3_mem_we), .mem_addr(r3_mem_addr),
    .mem_wdata(r3_mem_wdata), .mem_rdata(r3_mem_rdata)
  );

  // BRAM model, read-first, one cycle of read latency.
  logic [15:0] bram [256];
  logic [15:0] rd_pipe = '0;
  initial for (int i = 0; i < 256; i++) bram[i] = 16'hA000 + 16'(i);
  always @(posedge clk) begin
    rd_pipe <= bram[mem_addr[7:0]];
    if (mem_en && mem_we) bram[mem_addr[7:0]] <= mem_wdata;
  end
  assign mem_rdata = rd_pipe;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          port;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int unsigned cyc;
  } ack_t;
  typedef struct {
    logic [15:0] data;
    int unsigned cyc;
  } rd_t;

  ack_t ack_q[$];
  rd_t  cpu_rq[$];
  rd_t  vid_rq[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_en = 1'b0;
    end else begin
      if (cpu_ack || vid_ack) begin
        if (ack_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_ack: got cpu_ack=%0b vid_ack=%0b expected none (cycle %0d)",
                   cpu_ack, vid_ack, cyc);
        end else begin
          ack_t a;
          a = ack_q.pop_front();
          chk("ack_owner", {31'b0, vid_ack}, {31'b0, a.port});
          chk("ack_cycle", cyc, a.cyc);
          chk("ack_mem_we", {31'b0, mem_we}, {31'b0, a.we});
          chk("ack_mem_addr", {16'b0, mem_addr}, {16'b0, a.addr});
          chk("ack_mem_wdata", {16'b0, mem_wdata}, {16'b0, a.wdata});
        end
      end
      if (mem_en || cpu_ack || vid_ack) begin
        chk("mem_en_vs_ack", {31'b0, mem_en}, {31'b0, cpu_ack | vid_ack});
        chk("mem_en_back_to_back", {31'b0, prev_en}, 32'd0);
      end
      if (cpu_rvalid) begin
        chk("cpu_rvalid_with_ack", {31'b0, cpu_ack}, 32'd0);
        if (cpu_rq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_cpu_rvalid: got rdata 0x%0h expected no pulse (cycle %0d)",
                   cpu_rdata, cyc);
        end else begin
          rd_t r;
          r = cpu_rq.pop_front();
          chk("cpu_rvalid_cycle", cyc, r.cyc);
          chk("cpu_rdata", {16'b0, cpu_rdata}, {16'b0, r.data});
        end
      end
      if (vid_rvalid) begin
        chk("vid_rvalid_with_ack", {31'b0, vid_ack}, 32'd0);
        if (vid_rq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_vid_rvalid: got rdata 0x%0h expected no pulse (cycle %0d)",
                   vid_rdata, cyc);
        end else begin
          rd_t r;
          r = vid_rq.pop_front();
          chk("vid_rvalid_cycle", cyc, r.cyc);
          chk("vid_rdata", {16'b0, vid_rdata}, {16'b0, r.data});
        end
      end
      prev_en = mem_en;
    end
  end

  // One isolated access; request dropped and inputs scrambled during ISSUE.
  task automatic single(input bit port, input bit we, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] rdat);
    int unsigned c;
    c = cyc;
    ack_q.push_back('{port: port, we: we, addr: addr, wdata: wdata, cyc: c + 1});
    if (!we) begin
      if (port == OWN_VID) vid_rq.push_back('{data: rdat, cyc: c + 3});
      else                 cpu_rq.push_back('{data: rdat, cyc: c + 3});
    end
    if (port == OWN_VID) begin
      vid_req = 1'b1; vid_we = we; vid_addr = addr; vid_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
    tick();
    if (port == OWN_VID) begin
      vid_req = 1'b0; vid_we = ~we; vid_addr = ~addr; vid_wdata = ~wdata;
    end else begin
      cpu_req = 1'b0; cpu_we = ~we; cpu_addr = ~addr; cpu_wdata = ~wdata;
    end
    repeat (we ? 2 : 3) tick();
  endtask

  initial begin
    int unsigned c;
    int ci, vi, n;

    tick();
    tick();
    reset = 1'b0;
    r3_reset = 1'b0;

    chk("rst_ctrl", {26'b0, cpu_ack, vid_ack, cpu_rvalid, vid_rvalid, mem_en, mem_we}, 32'd0);
    chk("rst_mem_addr", {16'b0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {16'b0, mem_wdata}, 32'd0);
    chk("rst_cpu_rdata", {16'b0, cpu_rdata}, 32'd0);
    chk("rst_vid_rdata", {16'b0, vid_rdata}, 32'd0);

    // Contention straight out of reset: CPU wins the first tie.
    c = cyc;
    ack_q.push_back('{port: OWN_CPU, we: 1'b1, addr: 16'h0001, wdata: 16'h1111, cyc: c + 1});
    ack_q.push_back('{port: OWN_VID, we: 1'b0, addr: 16'h0002, wdata: 16'h0000, cyc: c + 3});
    vid_rq.push_back('{data: 16'hA002, cyc: c + 5});
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0001; cpu_wdata = 16'h1111;
    vid_req = 1'b1; vid_we = 1'b0; vid_addr = 16'h0002; vid_wdata = 16'h0000;
    tick();
    cpu_req = 1'b0;
    tick();
    tick();
    vid_req = 1'b0;
    repeat (3) tick();

    // Continuous contention: 8 writes alternating CPU, VID.
    c = cyc;
    for (int k = 0; k < 8; k++) begin
      int idx;
      idx = k / 2;
      if (k % 2 == 0)
        ack_q.push_back('{port: OWN_CPU, we: 1'b1, addr: 16'h0020 + 16'(idx),
                          wdata: 16'hC000 + 16'(idx), cyc: c + 1 + 2 * k});
      else
        ack_q.push_back('{port: OWN_VID, we: 1'b1, addr: 16'h0040 + 16'(idx),
                          wdata: 16'hD000 + 16'(idx), cyc: c + 1 + 2 * k});
    end
    ci = 0;
    vi = 0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 16'hC000;
    vid_req = 1'b1; vid_we = 1'b1; vid_addr = 16'h0040; vid_wdata = 16'hD000;
    for (int t = 0; t < 24 && (cpu_req || vid_req); t++) begin
      tick();
      if (cpu_ack) begin
        ci++;
        if (ci < 4) begin
          cpu_addr = 16'h0020 + 16'(ci); cpu_wdata = 16'hC000 + 16'(ci);
        end else cpu_req = 1'b0;
      end
      if (vid_ack) begin
        vi++;
        if (vi < 4) begin
          vid_addr = 16'h0040 + 16'(vi); vid_wdata = 16'hD000 + 16'(vi);
        end else vid_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
    vid_req = 1'b0;
    tick();

    // Withdrawal: VID read, request dropped in ISSUE, still completes once.
    single(OWN_VID, 1'b0, 16'h0041, 16'h0000, 16'hD001);

    // Back-to-back CPU writes with req held high.
    c = cyc;
    for (int i = 0; i < 3; i++)
      ack_q.push_back('{port: OWN_CPU, we: 1'b1, addr: 16'h0030 + 16'(i),
                        wdata: 16'h3000 + 16'(i), cyc: c + 1 + 2 * i});
    n = 0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0030; cpu_wdata = 16'h3000;
    for (int t = 0; t < 10 && cpu_req; t++) begin
      tick();
      if (cpu_ack) begin
        n++;
        if (n < 3) begin
          cpu_addr = 16'h0030 + 16'(n); cpu_wdata = 16'h3000 + 16'(n);
        end else cpu_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
    tick();

    single(OWN_CPU, 1'b0, 16'h0031, 16'h0000, 16'h3001);
    single(OWN_CPU, 1'b1, 16'h0010, 16'hBEEF, 16'h0000);
    single(OWN_CPU, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);
    repeat (3) tick();
    chk("cpu_rdata_hold", {16'b0, cpu_rdata}, 32'h0000_BEEF);
    chk("vid_rdata_hold", {16'b0, vid_rdata}, 32'h0000_D001);

    // Reset during WAIT on the RD_LAT=3 instance.
    r3_cpu_req = 1'b1; r3_cpu_we = 1'b0; r3_cpu_addr = 16'h0005;
    tick();
    chk("r3_ack", {31'b0, r3_cpu_ack}, 32'd1);
    chk("r3_mem_en", {31'b0, r3_mem_en}, 32'd1);
    r3_cpu_req = 1'b0;
    tick();
    tick();
    r3_reset = 1'b1;
    #1;
    chk("r3_rst_ctrl", {26'b0, r3_cpu_ack, r3_vid_ack, r3_cpu_rvalid, r3_vid_rvalid,
                        r3_mem_en, r3_mem_we}, 32'd0);
    chk("r3_rst_mem_addr", {16'b0, r3_mem_addr}, 32'd0);
    chk("r3_rst_rdata", {r3_cpu_rdata, r3_vid_rdata}, 32'd0);
    chk("r3_rst_mem_wdata", {16'b0, r3_mem_wdata}, 32'd0);
    tick();
    r3_reset = 1'b0;
    for (int t = 0; t < 6; t++) begin
      tick();
      chk("r3_no_rvalid", {30'b0, r3_cpu_rvalid, r3_vid_rvalid}, 32'd0);
    end
    r3_cpu_req = 1'b1; r3_cpu_we = 1'b0; r3_cpu_addr = 16'h0007;
    tick();
    chk("r3_ack_after_reset", {31'b0, r3_cpu_ack}, 32'd1);
    chk("r3_mem_addr", {16'b0, r3_mem_addr}, 32'h0000_0007);
    r3_cpu_req = 1'b0;
    for (int t = 2; t <= 5; t++) begin
      tick();
      chk("r3_rvalid_timing", {31'b0, r3_cpu_rvalid}, (t == 5) ? 32'd1 : 32'd0);
    end
    chk("r3_rdata", {16'b0, r3_cpu_rdata}, 32'h0000_5A5A);

    repeat (3) tick();
    chk("ack_queue_drained", ack_q.size(), 32'd0);
    chk("cpu_rd_queue_drained", cpu_rq.size(), 32'd0);
    chk("vid_rd_queue_drained", vid_rq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares the single-port block RAM between two requesters: the CPU load/store path (port CPU) and the Pong game/video logic (port VID).
- Serialises accesses through a small state machine. Arbitrates round-robin on contention. Returns read data with a valid pulse.
- Sits between the CPU control/datapath and the BRAM instance, replacing the CPU's direct BRAM connection.

Parameters:
- ADDR_W, 16, BRAM address width.
- DATA_W, 16, BRAM data width.
- RD_LAT, 1, BRAM read latency in cycles (mem_rdata valid RD_LAT cycles after the mem_en cycle); legal range 1..4.

Ports:
- clk  in  1  single system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU access request; held with cpu_we/addr/wdata stable until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU access address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle pulse: CPU access issued to memory this cycle.
- cpu_rdata  out  DATA_W  CPU read data; holds value until next cpu_rvalid.
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid.
- vid_req, vid_we, vid_addr, vid_wdata, vid_ack, vid_rdata, vid_rvalid: same directions, widths and meanings as the CPU port, for the video/game requester.
- mem_en  out  1  BRAM enable.
- mem_we  out  1  BRAM write enable.
- mem_addr  out  ADDR_W  BRAM address.
- mem_wdata  out  DATA_W  BRAM write data.
- mem_rdata  in  DATA_W  BRAM read data.

Behaviour:
- Reset values:
  - State IDLE; last_owner = VID, so CPU wins the first tie.
  - All acks, rvalids, mem_en and mem_we are 0.
  - mem_addr, mem_wdata, cpu_rdata, vid_rdata and the latch registers are 0.
- States:
  - IDLE:
    - No request: stay in IDLE.
    - One request: grant it.
    - Both requesting: grant the port != last_owner.
    - On grant: latch owner, we, addr, wdata into registers; set last_owner = owner; go to ISSUE.
  - ISSUE (exactly 1 cycle):
    - mem_en = 1; mem_we = latched we; mem_addr/mem_wdata = latched values.
    - Owner's ack = 1.
    - Latched we = 1: go to IDLE. Latched we = 0: load wait counter = RD_LAT, go to WAIT.
  - WAIT:
    - mem_en = 0; counter decrements each cycle.
    - In the cycle where the counter is 1: register mem_rdata into the owner's rdata; go to IDLE with the owner's rvalid = 1 in the next cycle (registered pulse).
- Timing, with the request first seen in IDLE at cycle 0:
  - ack at cycle 1.
  - Write completes in the BRAM at cycle 1.
  - Read rvalid at cycle 2+RD_LAT (= cycle 3 for RD_LAT=1).
- Throughput:
  - Write: one access per 2 cycles.
  - Read: one per RD_LAT+2 cycles.
  - Fairness: a port waits at most one foreign access under continuous contention.
- Outside ISSUE: mem_en = mem_we = 0; mem_addr/mem_wdata keep their latched values.
- Handshake:
  - Request inputs are sampled only in IDLE. After the latch, changes to req/addr/we/wdata do not affect the current access.
  - A req withdrawn after the latch still completes, including ack and rvalid.
  - req still high in the IDLE cycle after ack counts as a new request (back-to-back allowed, subject to round-robin).
- rvalid for a port never coincides with that port's ack. The only coincidence of rvalid and ack is one port's rvalid with the other port's grant path, and even that cannot overlap: rvalid is asserted in IDLE, and ack only in ISSUE.
- Reset asserted in any state: immediate return to IDLE with reset values. A pending read is discarded and no rvalid is issued.
- Address and data are passed unmodified; no width conversion.

Decomposition:
- Shared package bram_arb_pkg holds:
  - State encodings: IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2; 2'd3 is illegal and returns to IDLE.
  - Owner constants: OWN_CPU = 1'b0, OWN_VID = 1'b1.
  - Default widths.
- One sub-module: bram_arb_rr2.
  - Combinational 2-way round-robin picker.
  - Inputs: req_cpu, req_vid, last_owner. Outputs: grant_valid, grant_owner.
- The top level holds the FSM, latch registers, wait counter and read-return registers.

Test Plan:
- CPU only: cpu write addr 0x0010 data 0xBEEF at cycle 0 -> cpu_ack at cycle 1 with mem_en=1, mem_we=1, mem_addr=0x0010, mem_wdata=0xBEEF; no vid_ack.
- CPU read after write (RD_LAT=1, BRAM model): cpu read 0x0010 -> cpu_ack at cycle 1, cpu_rvalid pulse at cycle 3 with cpu_rdata=0xBEEF; cpu_rdata stable afterwards.
- Contention from reset: both req at cycle 0 (cpu write 0x0001, vid read 0x0002) -> CPU acked first, VID acked second. Under continuous requests from both, grants alternate CPU, VID, CPU, VID for 8 accesses.
- Withdrawal: vid read request latched, vid_req dropped during ISSUE -> vid_ack and vid_rvalid still occur with correct data; no second access.
- Reset mid-read: assert reset during WAIT with RD_LAT=3 -> all outputs 0 immediately, no rvalid ever appears for that read; after release a CPU request gets ack one cycle after it is seen.
- Back-to-back: cpu_req held high for 3 writes, vid idle -> cpu_ack at cycles 1, 3, 5; mem_en is never high in two consecutive cycles.
